// File: rtl/key_click_decoder.sv
// Groups debounced key-press strobes into click events and queues them in a FIFO.
// Optional KEY_CLICK_DROP_CNT_EN adds an 8-bit saturating drop counter output.
module key_click_decoder #(
    parameter int CLK_FREQ_MHZ = 200,
    parameter int WINDOW_US    = 300,
    parameter int MAX_CLICKS   = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk_i,
    input  logic                              srst_n_i,
    input  logic                              key_pressed_stb_i,
    output logic [$clog2(MAX_CLICKS+1)-1:0]   click_cnt_o,
    output logic                              click_valid_o,
    input  logic                              click_ready_i,
`ifdef KEY_CLICK_DROP_CNT_EN
    output logic [7:0]                        drop_cnt_o,
`endif
    output logic                              overflow_o
);

    localparam int WINDOW_CYCLES = WINDOW_US * CLK_FREQ_MHZ;
    localparam int CNT_W = $clog2(MAX_CLICKS + 1);
    localparam int TMR_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] ONE_T = TMR_W'(1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [TMR_W-1:0] timer, timer_n;
    logic             push;
    logic [CNT_W-1:0] push_cnt;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
            timer <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            timer <= timer_n;
        end
    end

    assign cnt_inc = cnt + ONE_C;

    // A strobe always wins over the timeout, so the window is inclusive.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        timer_n  = timer;
        push     = 1'b0;
        push_cnt = cnt;
        unique case (state)
            IDLE: begin
                if (key_pressed_stb_i) begin
                    state_n = COLLECT;
                    cnt_n   = ONE_C;
                    timer_n = '0;
                end
            end
            COLLECT: begin
                if (key_pressed_stb_i) begin
                    timer_n = '0;
                    if (cnt_inc == MAX_C) begin
                        push     = 1'b1;
                        push_cnt = MAX_C;
                        state_n  = IDLE;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else if (timer == TMR_LAST) begin
                    push     = 1'b1;
                    push_cnt = cnt;
                    state_n  = IDLE;
                    cnt_n    = '0;
                    timer_n  = '0;
                end else begin
                    timer_n = timer + ONE_T;
                end
            end
        endcase
    end

    logic [CNT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             empty, full, pop, wr_en, drop;
    logic             overflow;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && click_ready_i;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= push_cnt;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            overflow <= drop;
        end
    end

    assign click_valid_o = !empty;
    assign click_cnt_o   = mem[rd_ptr[AW-1:0]];
    assign overflow_o    = overflow;

`ifdef KEY_CLICK_DROP_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            drop_cnt <= 8'd0;
        end else if (drop && drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_cnt_o = drop_cnt;
`endif

endmodule

// File: tb/tb_key_click_decoder.sv
// Bench for key_click_decoder: timestamp/queue reference model plus directed literals.
module tb_key_click_decoder;

    localparam int W     = 10;
    localparam int MAXC  = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       srst_n = 1'b0;
    logic       stb = 1'b0;
    logic       ready = 1'b1;
    logic [2:0] click_cnt_o;
    logic       click_valid_o;
    logic       overflow_o;
`ifdef KEY_CLICK_DROP_CNT_EN
    logic [7:0] drop_cnt_o;
`endif

    key_click_decoder #(
        .CLK_FREQ_MHZ(10),
        .WINDOW_US(1),
        .MAX_CLICKS(MAXC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .srst_n_i(srst_n),
        .key_pressed_stb_i(stb),
        .click_cnt_o(click_cnt_o),
        .click_valid_o(click_valid_o),
        .click_ready_i(ready),
`ifdef KEY_CLICK_DROP_CNT_EN
        .drop_cnt_o(drop_cnt_o),
`endif
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: group tracked by last-strobe timestamp, FIFO as a queue.
    bit chk_on = 0;
    int q[$];
    bit m_in = 0;
    int m_cnt = 0;
    int m_last = 0;
    bit m_ovf = 0;
    int m_drop = 0;
    int cyc = 0;

    always @(negedge clk) begin
        bit push;
        bit pop;
        int pv;
        if (chk_on) begin
            check("valid", click_valid_o, 32'(q.size() != 0));
            if (q.size() != 0) check("cnt", click_cnt_o, q[0]);
            check("overflow", overflow_o, 32'(m_ovf));
`ifdef KEY_CLICK_DROP_CNT_EN
            check("drop_cnt", drop_cnt_o, m_drop);
`endif
        end
        if (!srst_n) begin
            q.delete();
            m_in = 0;
            m_cnt = 0;
            m_ovf = 0;
            m_drop = 0;
        end else begin
            push = 0;
            pv = 0;
            if (!m_in) begin
                if (stb) begin
                    m_in = 1;
                    m_cnt = 1;
                    m_last = cyc;
                end
            end else if (stb) begin
                m_cnt++;
                m_last = cyc;
                if (m_cnt == MAXC) begin
                    push = 1;
                    pv = MAXC;
                    m_in = 0;
                end
            end else if (cyc - m_last == W) begin
                push = 1;
                pv = m_cnt;
                m_in = 0;
            end
            pop = (q.size() != 0) && ready;
            if (pop) void'(q.pop_front());
            m_ovf = 0;
            if (push) begin
                if (q.size() < DEPTH) q.push_back(pv);
                else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        cyc++;
    end

    int sq[$];
    bit st [256];
    logic rv [256];
    logic [2:0] rc [256];
    logic ro [256];

    task automatic do_reset();
        @(posedge clk);
        #1;
        srst_n = 1'b0;
        stb = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk_on = 1;
        check("rst_valid", click_valid_o, 0);
        check("rst_cnt", click_cnt_o, 0);
        check("rst_ovf", overflow_o, 0);
    endtask

    task automatic play(input int len, input int rdy_from, input int rst_at);
        for (int i = 0; i < 256; i++) st[i] = 0;
        foreach (sq[i]) st[sq[i]] = 1;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            srst_n = (c == rst_at) ? 1'b0 : 1'b1;
            stb = st[c];
            ready = (c >= rdy_from) ? 1'b1 : 1'b0;
            @(negedge clk);
            rv[c] = click_valid_o;
            rc[c] = click_cnt_o;
            ro[c] = overflow_o;
        end
        stb = 1'b0;
        ready = 1'b1;
    endtask

    initial begin
        int n;
        int dens;
        int rp;

        do_reset();

        sq = '{5};
        play(25, 0, -1);
        check("s1_v15", rv[15], 0);
        check("s1_v16", rv[16], 1);
        check("s1_c16", rc[16], 1);
        check("s1_v17", rv[17], 0);
        n = 0;
        for (int i = 0; i < 25; i++) if (ro[i] !== 1'b0) n++;
        check("s1_noovf", n, 0);

        do_reset();
        sq = '{0, 4, 8};
        play(25, 0, -1);
        check("s2_v18", rv[18], 0);
        check("s2_v19", rv[19], 1);
        check("s2_c19", rc[19], 3);

        do_reset();
        sq = '{0, 10};
        play(30, 0, -1);
        check("s3a_v20", rv[20], 0);
        check("s3a_v21", rv[21], 1);
        check("s3a_c21", rc[21], 2);

        do_reset();
        sq = '{0, 11};
        play(30, 0, -1);
        check("s3b_v11", rv[11], 1);
        check("s3b_c11", rc[11], 1);
        check("s3b_v12", rv[12], 0);
        check("s3b_v21", rv[21], 0);
        check("s3b_v22", rv[22], 1);
        check("s3b_c22", rc[22], 1);

        do_reset();
        sq = '{0, 2, 4, 6, 8};
        play(25, 0, -1);
        check("s4_v6", rv[6], 0);
        check("s4_v7", rv[7], 1);
        check("s4_c7", rc[7], 4);
        check("s4_v19", rv[19], 1);
        check("s4_c19", rc[19], 1);

        do_reset();
        sq = '{0, 20, 40, 60, 80};
        play(110, 100, -1);
        check("s5_v11", rv[11], 1);
        check("s5_o90", ro[90], 0);
        check("s5_o91", ro[91], 1);
        check("s5_o92", ro[92], 0);
`ifdef KEY_CLICK_DROP_CNT_EN
        check("s5_drop", drop_cnt_o, 1);
`endif
        for (int i = 100; i < 104; i++) begin
            check("s5_drain_v", rv[i], 1);
            check("s5_drain_c", rc[i], 1);
        end
        check("s5_v104", rv[104], 0);

        do_reset();
        sq = '{0, 3, 20};
        play(40, 0, 5);
        n = 0;
        for (int i = 0; i <= 30; i++) if (rv[i] !== 1'b0) n++;
        check("s6_novalid", n, 0);
        check("s6_v31", rv[31], 1);
        check("s6_c31", rc[31], 1);

        do_reset();
        dens = 10;
        rp = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: dens = 3;
                    1: dens = 10;
                    2: dens = 30;
                    default: dens = 60;
                endcase
                case ($urandom_range(0, 3))
                    0: rp = 0;
                    1: rp = 30;
                    2: rp = 90;
                    default: rp = 100;
                endcase
            end
            @(posedge clk);
            #1;
            stb = ($urandom_range(0, 99) < dens);
            ready = ($urandom_range(0, 99) < rp);
            srst_n = ($urandom_range(0, 999) != 0);
        end

        do_reset();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
